// File: rtl/scaler_line_buffer.sv
// Circular multi-line buffer: pixels arrive row by row in raster order and are
// read back one column at a time, with every stored line presented as a tap.
module scaler_line_buffer #(
  parameter int LINE_NUM      = 8,
  parameter int LINE_DEEP     = 1920,
  parameter int ADDR_BITWIDTH = $clog2(LINE_DEEP),
  parameter int DATA_BITWIDTH = 8,
  parameter int CHANNEL_NUM   = 1,
  localparam int PIX_W        = DATA_BITWIDTH * CHANNEL_NUM,
  localparam int CNT_W        = $clog2(LINE_NUM + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        sof,
  input  logic [ADDR_BITWIDTH:0]      cfg_width,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [PIX_W-1:0]            s_data,
  input  logic                        rd_en,
  input  logic [ADDR_BITWIDTH-1:0]    rd_addr,
  input  logic                        rd_release,
  output logic [CNT_W-1:0]            rd_lines,
  output logic                        m_valid,
  output logic [PIX_W*LINE_NUM-1:0]   m_data
);

  localparam int LINE_W = $clog2(LINE_NUM);
  localparam logic [ADDR_BITWIDTH:0]   DEEP_W    = (ADDR_BITWIDTH + 1)'(LINE_DEEP);
  localparam logic [ADDR_BITWIDTH:0]   WIDTH_ONE = (ADDR_BITWIDTH + 1)'(1);
  localparam logic [ADDR_BITWIDTH-1:0] COL_ONE   = ADDR_BITWIDTH'(1);
  localparam logic [CNT_W-1:0]         FULL      = CNT_W'(LINE_NUM);
  localparam logic [CNT_W-1:0]         CNT_ONE   = CNT_W'(1);
  localparam logic [LINE_W-1:0]        LAST_LINE = LINE_W'(LINE_NUM - 1);
  localparam logic [LINE_W-1:0]        LINE_ONE  = LINE_W'(1);

  logic [ADDR_BITWIDTH:0]     width_q;
  logic [ADDR_BITWIDTH-1:0]   wr_col;
  logic [LINE_W-1:0]          wr_line;
  logic [LINE_W-1:0]          rd_base;
  logic [LINE_W-1:0]          base_d1;
  logic [CNT_W-1:0]           fill;
  logic                       wr_fire;
  logic                       line_done;
  logic                       rel_fire;
  logic                       rd_v1;
  logic [PIX_W*LINE_NUM-1:0]  ram_flat;
  logic [PIX_W*LINE_NUM-1:0]  taps;

  function automatic logic [LINE_W-1:0] next_line(input logic [LINE_W-1:0] p);
    return (p == LAST_LINE) ? '0 : p + LINE_ONE;
  endfunction

  assign s_ready   = (fill != FULL);
  assign rd_lines  = fill;
  assign wr_fire   = s_valid & s_ready & ~sof;
  assign line_done = wr_fire & ({1'b0, wr_col} == (width_q - WIDTH_ONE));
  assign rel_fire  = rd_release & ~sof & (fill != '0);

  // Pointer and occupancy bookkeeping; sof restarts the frame and wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= DEEP_W;
      wr_col  <= '0;
      wr_line <= '0;
      rd_base <= '0;
      fill    <= '0;
    end else if (sof) begin
      width_q <= ((cfg_width == '0) || (cfg_width > DEEP_W)) ? DEEP_W : cfg_width;
      wr_col  <= '0;
      wr_line <= '0;
      rd_base <= '0;
      fill    <= '0;
    end else begin
      if (wr_fire) begin
        if (line_done) begin
          wr_col  <= '0;
          wr_line <= next_line(wr_line);
        end else begin
          wr_col <= wr_col + COL_ONE;
        end
      end
      if (rel_fire) begin
        rd_base <= next_line(rd_base);
      end
      if (line_done && !rel_fire) begin
        fill <= fill + CNT_ONE;
      end else if (!line_done && rel_fire) begin
        fill <= fill - CNT_ONE;
      end
    end
  end

  for (genvar g = 0; g < LINE_NUM; g++) begin : g_line
    logic [PIX_W-1:0] mem [LINE_DEEP];
    logic [PIX_W-1:0] q;

    // Read and write share one block so a same-address collision returns the old word.
    always_ff @(posedge clk) begin
      if (rd_en) begin
        q <= mem[rd_addr];
      end
      if (wr_fire && (wr_line == LINE_W'(g))) begin
        mem[wr_col] <= s_data;
      end
    end

    assign ram_flat[g*PIX_W +: PIX_W] = q;
  end

  always_comb begin
    taps = '0;
    for (int k = 0; k < LINE_NUM; k++) begin
      taps[k*PIX_W +: PIX_W] = ram_flat[((int'(base_d1) + k) % LINE_NUM)*PIX_W +: PIX_W];
    end
  end

  // Each read carries the rd_base it saw, so a release mid-flight cannot reorder taps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1   <= 1'b0;
      base_d1 <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      rd_v1   <= rd_en;
      if (rd_en) begin
        base_d1 <= rd_base;
      end
      m_valid <= rd_v1;
      if (rd_v1) begin
        m_data <= taps;
      end
    end
  end

endmodule

// File: doc/scaler_line_buffer.md
# scaler_line_buffer

Multi-line circular line buffer for the scaler datapath: pixels are written in raster order one row at a time, and read back one column at a time, with all `LINE_NUM` stored lines presented in parallel as vertical filter taps. Generalises the fixed row-in/column-out RAM bank with per-channel pixel width, a runtime line width, automatic line-pointer rotation, ready/valid write flow control, line-release handshake and oldest-to-newest tap ordering. Sits between the horizontal scaler stage and the vertical filter.

## Interface
- `LINE_NUM`, 8: number of stored lines, which is also the number of output taps; must be ≥2.
- `LINE_DEEP`, 1920: maximum pixels per line.
- `ADDR_BITWIDTH`, CLOG2(LINE_DEEP): column address width.
- `DATA_BITWIDTH`, 8: bits per channel.
- `CHANNEL_NUM`, 1: channels per pixel; PIX_W = DATA_BITWIDTH*CHANNEL_NUM.

Ports:
- `clk`  in  1  single clock for all logic and memory.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sof`  in  1  start-of-frame pulse; synchronously clears pointers and counts, and latches `cfg_width`.
- `cfg_width`  in  ADDR_BITWIDTH+1  pixels per line; valid range 1..LINE_DEEP.
- `s_valid`  in  1  write pixel valid.
- `s_ready`  out  1  buffer can accept a pixel.
- `s_data`  in  PIX_W  write pixel.
- `rd_en`  in  1  column read request.
- `rd_addr`  in  ADDR_BITWIDTH  column to read.
- `rd_release`  in  1  pulse that frees the oldest complete line.
- `rd_lines`  out  CLOG2(LINE_NUM+1)  number of complete lines held.
- `m_valid`  out  1  tap data valid.
- `m_data`  out  PIX_W*LINE_NUM  taps; tap k occupies bits [PIX_W*(k+1)-1 : PIX_W*k]; tap 0 is the oldest line.

## Operation
- Storage: `LINE_NUM` inferred simple-dual-port memories of `LINE_DEEP` x PIX_W each. Contents are not reset.
- Write side:
  - A write occurs on `s_valid & s_ready` to line `wr_line`, column `wr_col`.
  - `wr_col` increments on each write.
  - At `wr_col == width_q-1`, `wr_col` returns to 0, `wr_line` advances modulo `LINE_NUM`, and `fill` increments.
- `s_ready = (fill != LINE_NUM)`. This is combinational from registered `fill`.
- Release:
  - `rd_release` with `fill > 0` decrements `fill` and advances `rd_base` modulo `LINE_NUM`.
  - `rd_release` with `fill == 0` is ignored.
- Simultaneous line completion and release in the same cycle: `fill` is unchanged, and both pointers advance.
- Read side:
  - `rd_en` reads `rd_addr` from all lines.
  - Tap k = line (rd_base + k) mod LINE_NUM, using the `rd_base` value sampled in the `rd_en` cycle.
  - Taps with k ≥ `rd_lines` carry stale or partial data and are the consumer's responsibility.
  - `rd_addr ≥ width_q` returns undefined data, but `m_valid` still asserts.
- `sof` has priority over all other inputs in its cycle. It clears `wr_col`, `wr_line`, `rd_base` and `fill`, and loads `width_q`.
  - A `cfg_width` of 0 or greater than `LINE_DEEP` loads `LINE_DEEP`.
  - A write or release in the same cycle as `sof` is discarded.
  - Reads already in flight complete normally.
- `rd_lines = fill`.

## Timing
- Reset values:
  - `s_ready` = 1, because `fill` = 0.
  - `rd_lines` = 0, `m_valid` = 0, `m_data` = 0.
  - `width_q` = `LINE_DEEP`.
  - All pointers = 0.
- Write: data is stored at the clock edge of the handshake.
- `fill`/`rd_lines` update one cycle after the completing write or the release.
- Read latency is 2 cycles:
  - Cycle N: `rd_en` is sampled.
  - Cycle N+1: memory output register.
  - Cycle N+2: tap-rotation register; `m_valid` = 1 with `m_data` valid.
- Fully pipelined: one read per cycle, and back-to-back `rd_en` gives back-to-back `m_valid`.
- Read and write to the same line and column in the same cycle returns the old data (read-first).
- `s_ready` falls in the cycle after the write that fills line `LINE_NUM`. It rises in the cycle after a release.
- `rd_release` with reads in flight: those reads keep their sampled `rd_base`, so tap order is not corrupted.
- Reset asserted mid-frame: all state clears immediately, and `m_valid` drops without completing in-flight reads.

## Test plan
- **Fill and read.** Setup: LINE_NUM=4, cfg_width=4 via `sof`. Stimulus: write pixels 0..15 (line L holds 4L..4L+3). Required:
  - `rd_lines` = 4 and `s_ready` = 0.
  - `rd_en` at addr 2 gives `m_data` taps {2,6,10,14} two cycles later.
- **Wrap and rotation.** Stimulus: from the full state, pulse `rd_release` once, then write 16..19. Required:
  - `rd_lines` = 3 after the release, then 4 again.
  - Addr 0 gives taps {4,8,12,16}, with tap 0 = 4.
- **Backpressure.** Stimulus: hold `s_valid` = 1 with `fill` = 4. Required:
  - No write occurs and `wr_col` is unchanged.
  - Releasing 1 line raises `s_ready` in the next cycle, and exactly 4 further pixels are accepted before `s_ready` falls.
- **Simultaneous events.** Stimulus: the last-pixel write and `rd_release` in the same cycle. Required: `rd_lines` unchanged, and the next read shows taps shifted by one line.
- **sof and clamping.** Stimulus: `sof` mid-line with `cfg_width` = 0. Required:
  - `rd_lines` = 0 and `wr_col` = 0.
  - A line completes only after `LINE_DEEP` writes.
  - A write in the `sof` cycle is dropped.
- **Reset.** Stimulus: assert `rst_n` = 0 while `m_valid` = 1 and `fill` = 3. Required:
  - `m_valid`, `m_data` and `rd_lines` go to 0 asynchronously, and `s_ready` = 1.
  - After deassertion, the first write lands in line 0, column 0.
